// File: rtl/ysyx_22040088_mem_pkg.sv
// Shared types and widths for the data-memory arbiter.
package ysyx_22040088_mem_pkg;

  localparam int XLEN   = 64;
  localparam int ILEN   = 32;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IFU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22040088_mem_arb_if.sv
// Requester and memory handshake bundle around the arbiter.
interface ysyx_22040088_mem_arb_if;
  import ysyx_22040088_mem_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_addr;
  logic              ifu_flush;
  logic              ifu_resp_valid;
  logic [ILEN-1:0]   ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [XLEN-1:0]   lsu_addr;
  logic [XLEN-1:0]   lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [XLEN-1:0]   lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  // Arbiter view.
  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_flush,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // Environment view: requesters plus memory.
  modport master (
    output ifu_req_valid, ifu_addr, ifu_flush,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22040088_arb_prio.sv
// Grant decision for the arbiter: LSU first, IFU forced through after
// STARVE_LIM consecutive LSU grants while it was waiting.
module ysyx_22040088_arb_prio
  import ysyx_22040088_mem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  input  logic ifu_flush_i,
  output logic ifu_grant_o,
  output logic lsu_grant_o
);

  localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             below_lim;
  logic             lsu_wins;

  // A flushing IFU that won arbitration blocks the cycle rather than handing it to LSU.
  always_comb begin
    below_lim    = (starve_cnt_q < LIM);
    lsu_wins     = lsu_valid_i && (below_lim || !ifu_valid_i);
    lsu_grant_o  = idle_i && lsu_wins;
    ifu_grant_o  = idle_i && ifu_valid_i && !lsu_wins && !ifu_flush_i;
    starve_cnt_d = starve_cnt_q;
    if (ifu_grant_o) begin
      starve_cnt_d = '0;
    end else if (lsu_grant_o && ifu_valid_i && below_lim) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22040088_mem_arb.sv
// Shares one data-memory port between IFU and LSU: one outstanding request,
// response routed back to its owner, fetch responses dropped after a flush.
module ysyx_22040088_mem_arb
  import ysyx_22040088_mem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22040088_mem_arb_if.slave bus_io
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              addr2_q, addr2_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              ifu_ready, lsu_ready;
  logic              flush_hit;
  logic              unused_addr_bits;

  ysyx_22040088_arb_prio #(
    .STARVE_LIM(STARVE_LIM)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (state_q == IDLE),
    .ifu_valid_i(bus_io.ifu_req_valid),
    .lsu_valid_i(bus_io.lsu_req_valid),
    .ifu_flush_i(bus_io.ifu_flush),
    .ifu_grant_o(ifu_ready),
    .lsu_grant_o(lsu_ready)
  );

  assign bus_io.ifu_req_ready = ifu_ready;
  assign bus_io.lsu_req_ready = lsu_ready;
  assign bus_io.mem_req_valid = (state_q == REQ);
  assign bus_io.mem_wen       = wen_q;
  assign bus_io.mem_addr      = addr_q;
  assign bus_io.mem_wdata     = wdata_q;
  assign bus_io.mem_wmask     = wmask_q;
  assign flush_hit            = bus_io.ifu_flush && (owner_q == OWN_IFU);
  assign unused_addr_bits     = ^bus_io.ifu_addr[1:0];

  // Fetches read the whole aligned doubleword; addr2 picks the half on return.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    addr2_d = addr2_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    bus_io.ifu_resp_valid = 1'b0;
    bus_io.ifu_rdata      = '0;
    bus_io.lsu_resp_valid = 1'b0;
    bus_io.lsu_rdata      = '0;
    unique case (state_q)
      IDLE: begin
        if (lsu_ready) begin
          state_d = REQ;
          owner_d = OWN_LSU;
          drop_d  = 1'b0;
          wen_d   = bus_io.lsu_wen;
          addr_d  = bus_io.lsu_addr;
          wdata_d = bus_io.lsu_wdata;
          wmask_d = bus_io.lsu_wmask;
        end else if (ifu_ready) begin
          state_d = REQ;
          owner_d = OWN_IFU;
          drop_d  = 1'b0;
          addr2_d = bus_io.ifu_addr[2];
          wen_d   = 1'b0;
          addr_d  = {bus_io.ifu_addr[XLEN-1:3], 3'b000};
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      REQ: begin
        if (flush_hit) drop_d = 1'b1;
        if (bus_io.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (flush_hit) drop_d = 1'b1;
        if (bus_io.mem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_LSU) begin
            bus_io.lsu_resp_valid = 1'b1;
            bus_io.lsu_rdata      = bus_io.mem_rdata;
          end else begin
            bus_io.ifu_resp_valid = !(drop_q || bus_io.ifu_flush);
            bus_io.ifu_rdata      = addr2_q ? bus_io.mem_rdata[XLEN-1:ILEN]
                                            : bus_io.mem_rdata[ILEN-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LSU;
      drop_q  <= 1'b0;
      addr2_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      addr2_q <= addr2_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_mem_arb.sv
// Self-checking bench for ysyx_22040088_mem_arb: transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ysyx_22040088_mem_arb;

  localparam int LIM = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ysyx_22040088_mem_arb_if bus ();

  ysyx_22040088_mem_arb #(
    .STARVE_LIM(LIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side controls used by the responder process.
  bit          memManual = 1'b0;
  logic        manReady  = 1'b0;
  logic        manResp   = 1'b0;
  logic [63:0] manData   = '0;
  logic [63:0] memData   = '0;
  int          stallLeft = 0;
  bit          hsSeen    = 1'b0;
  int          hsCount   = 0;
  int          ifuRespCount = 0;
  int          lsuRespCount = 0;

  // Observations captured by waitResp.
  logic [63:0] reqAddr, reqWdata;
  logic [7:0]  reqMask;
  logic        reqWen;
  bit          reqStable;

  // Transaction-level model state.
  bit          mBusy, mSent, mWho, mKill, mHi;
  int          mStreak;
  logic        mWen;
  logic [63:0] mAddr, mWdata;
  logic [7:0]  mWmask;
  logic        eIfuRdy, eLsuRdy, eMemVal, eIfuResp, eLsuResp;
  logic [63:0] eLsuData;
  logic [31:0] eIfuData;
  bit          lsuGo, ifuGo;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise one request and hold it until accepted; returns one cycle after the accept.
  task automatic applyStimulus(input bit isIfu, input bit wen, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] mask);
    bit acc;
    acc = 1'b0;
    if (isIfu) begin
      bus.ifu_addr      = addr;
      bus.ifu_req_valid = 1'b1;
    end else begin
      bus.lsu_wen       = wen;
      bus.lsu_addr      = addr;
      bus.lsu_wdata     = wdata;
      bus.lsu_wmask     = mask;
      bus.lsu_req_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = isIfu ? bus.ifu_req_ready : bus.lsu_req_ready;
      @(posedge clk);
      #1;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no ready, expected ready within 40 cycles");
    end
  endtask

  task automatic waitResp(input bit isIfu, output logic [63:0] data, output int lat);
    bit got;
    bit seenReq;
    got = 1'b0;
    seenReq = 1'b0;
    data = '0;
    lat = 0;
    reqStable = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        if (!seenReq) begin
          seenReq  = 1'b1;
          reqAddr  = bus.mem_addr;
          reqWen   = bus.mem_wen;
          reqWdata = bus.mem_wdata;
          reqMask  = bus.mem_wmask;
        end else if (bus.mem_addr != reqAddr || bus.mem_wen != reqWen ||
                     bus.mem_wdata != reqWdata || bus.mem_wmask != reqMask) begin
          reqStable = 1'b0;
        end
      end
      if (isIfu ? bus.ifu_resp_valid : bus.lsu_resp_valid) begin
        got  = 1'b1;
        lat  = i;
        data = isIfu ? {32'b0, bus.ifu_rdata} : bus.lsu_rdata;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL resp_timeout: got no response, expected one within 40 cycles");
    end
  endtask

  // Memory responder: zero-wait by default, optional stall, or manual drive.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(posedge clk);
      #2;
      if (memManual) begin
        bus.mem_req_ready  = manReady;
        bus.mem_resp_valid = manResp;
        bus.mem_rdata      = manData;
      end else begin
        bus.mem_resp_valid = 1'b0;
        if (hsSeen) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = memData;
        end
        if (bus.mem_req_valid) begin
          bus.mem_req_ready = (stallLeft == 0);
          if (stallLeft > 0) stallLeft--;
        end else begin
          bus.mem_req_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      hsSeen = bus.mem_req_valid && bus.mem_req_ready && !rst;
      if (hsSeen) hsCount++;
      if (bus.ifu_resp_valid) ifuRespCount++;
      if (bus.lsu_resp_valid) lsuRespCount++;
    end
  end

  // Model: at most one transaction outstanding; compare every cycle, then advance.
  always @(negedge clk) begin
    if (rst) begin
      mBusy = 0; mSent = 0; mWho = 0; mKill = 0; mHi = 0; mStreak = 0;
      mWen = 0; mAddr = '0; mWdata = '0; mWmask = '0;
    end
    eIfuRdy = 0; eLsuRdy = 0; eMemVal = 0; eIfuResp = 0; eLsuResp = 0;
    eLsuData = '0; eIfuData = '0; lsuGo = 0; ifuGo = 0;
    if (!mBusy) begin
      lsuGo   = bus.lsu_req_valid && (mStreak < LIM || !bus.ifu_req_valid);
      ifuGo   = bus.ifu_req_valid && !lsuGo && !bus.ifu_flush;
      eLsuRdy = lsuGo;
      eIfuRdy = ifuGo;
    end else if (!mSent) begin
      eMemVal = 1;
    end else if (bus.mem_resp_valid) begin
      if (mWho) begin
        eIfuResp = !(mKill || bus.ifu_flush);
        eIfuData = mHi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end else begin
        eLsuResp = 1;
        eLsuData = bus.mem_rdata;
      end
    end
    checkOutput("ifu_req_ready", bus.ifu_req_ready, eIfuRdy);
    checkOutput("lsu_req_ready", bus.lsu_req_ready, eLsuRdy);
    checkOutput("mem_req_valid", bus.mem_req_valid, eMemVal);
    checkOutput("ifu_resp_valid", bus.ifu_resp_valid, eIfuResp);
    checkOutput("lsu_resp_valid", bus.lsu_resp_valid, eLsuResp);
    checkOutput("mem_addr", bus.mem_addr, mAddr);
    checkOutput("mem_wen", bus.mem_wen, mWen);
    checkOutput("mem_wdata", bus.mem_wdata, mWdata);
    checkOutput("mem_wmask", bus.mem_wmask, mWmask);
    if (eIfuResp) checkOutput("ifu_rdata", bus.ifu_rdata, eIfuData);
    if (eLsuResp && !mWen) checkOutput("lsu_rdata", bus.lsu_rdata, eLsuData);
    if (!rst) begin
      if (!mBusy) begin
        if (lsuGo) begin
          mBusy = 1; mSent = 0; mWho = 0; mKill = 0;
          mWen = bus.lsu_wen; mAddr = bus.lsu_addr;
          mWdata = bus.lsu_wdata; mWmask = bus.lsu_wmask;
          if (bus.ifu_req_valid && mStreak < LIM) mStreak++;
        end else if (ifuGo) begin
          mBusy = 1; mSent = 0; mWho = 1; mKill = 0;
          mWen = 0; mAddr = {bus.ifu_addr[63:3], 3'b000};
          mWdata = '0; mWmask = '0; mHi = bus.ifu_addr[2];
          mStreak = 0;
        end
      end else begin
        if (mWho && bus.ifu_flush) mKill = 1;
        if (!mSent) begin
          if (bus.mem_req_ready) mSent = 1;
        end else if (bus.mem_resp_valid) begin
          mBusy = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] d;
    int          lat;
    int          hs0;
    int          nGrant;
    logic [15:0] grantVec;

    rst = 1'b0;
    bus.ifu_req_valid = 0; bus.ifu_addr = '0; bus.ifu_flush = 0;
    bus.lsu_req_valid = 0; bus.lsu_wen = 0; bus.lsu_addr = '0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    #1 rst = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("reset_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("reset_ifu_req_ready", bus.ifu_req_ready, 0);
    checkOutput("reset_lsu_req_ready", bus.lsu_req_ready, 0);
    checkOutput("reset_mem_addr", bus.mem_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);

    // LSU load, zero-wait memory.
    memData = 64'h1122334455667788;
    ifuRespCount = 0; lsuRespCount = 0;
    applyStimulus(0, 0, 64'h80000010, 64'h0, 8'hFF);
    waitResp(0, d, lat);
    checkOutput("load_data", d, 64'h1122334455667788);
    checkOutput("load_latency", lat, 2);
    checkOutput("load_mem_addr", reqAddr, 64'h80000010);
    tick(2);
    checkOutput("load_lsu_pulses", lsuRespCount, 1);
    checkOutput("load_ifu_pulses", ifuRespCount, 0);

    // IFU fetches of both halves.
    memData = 64'hAAAAAAAA_BBBBBBBB;
    applyStimulus(1, 0, 64'h80000004, 64'h0, 8'h0);
    waitResp(1, d, lat);
    checkOutput("fetch_hi_addr", reqAddr, 64'h80000000);
    checkOutput("fetch_hi_data", d, 64'hAAAAAAAA);
    applyStimulus(1, 0, 64'h80000000, 64'h0, 8'h0);
    waitResp(1, d, lat);
    checkOutput("fetch_lo_addr", reqAddr, 64'h80000000);
    checkOutput("fetch_lo_data", d, 64'hBBBBBBBB);

    // Both requesting continuously: starvation limit sequence.
    memData = 64'h0123456789ABCDEF;
    bus.ifu_addr = 64'h80000100;
    bus.lsu_wen = 0; bus.lsu_addr = 64'h80000200; bus.lsu_wmask = 8'hFF;
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
    nGrant = 0; grantVec = '0;
    for (int i = 0; i < 200 && nGrant < 10; i++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) begin
        grantVec[nGrant] = 1'b1;
        nGrant++;
      end else if (bus.lsu_req_ready) begin
        nGrant++;
      end
      @(posedge clk);
      #1;
    end
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    checkOutput("grant_count", nGrant, 10);
    checkOutput("grant_sequence", grantVec, 64'h210);
    tick(4);

    // Flush during a stalled fetch: response discarded, next fetch normal.
    memData = 64'hCCCCCCCC_DDDDDDDD;
    stallLeft = 3;
    hs0 = hsCount;
    ifuRespCount = 0;
    applyStimulus(1, 0, 64'h80001000, 64'h0, 8'h0);
    tick(1);
    bus.ifu_flush = 1;
    tick(1);
    bus.ifu_flush = 0;
    tick(8);
    checkOutput("flush_ifu_pulses", ifuRespCount, 0);
    checkOutput("flush_mem_handshakes", hsCount - hs0, 1);
    memData = 64'h11111111_22222222;
    applyStimulus(1, 0, 64'h80000008, 64'h0, 8'h0);
    waitResp(1, d, lat);
    checkOutput("post_flush_data", d, 64'h22222222);
    checkOutput("post_flush_addr", reqAddr, 64'h80000008);

    // Store held through a REQ stall.
    memData = 64'h0;
    stallLeft = 2;
    lsuRespCount = 0;
    applyStimulus(0, 1, 64'h80002000, 64'hDEADBEEF, 8'h0F);
    waitResp(0, d, lat);
    checkOutput("store_wen", reqWen, 1);
    checkOutput("store_wmask", reqMask, 8'h0F);
    checkOutput("store_wdata", reqWdata, 64'hDEADBEEF);
    checkOutput("store_stable", reqStable, 1);
    checkOutput("store_latency", lat, 4);
    tick(2);
    checkOutput("store_ack_pulses", lsuRespCount, 1);

    // Reset while waiting for a response; late response must be ignored.
    memManual = 1; manReady = 1; manResp = 0;
    applyStimulus(0, 0, 64'h80003000, 64'h0, 8'hFF);
    tick(1);
    rst = 1;
    @(negedge clk);
    checkOutput("midrst_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("midrst_mem_addr", bus.mem_addr, 0);
    checkOutput("midrst_lsu_resp", bus.lsu_resp_valid, 0);
    checkOutput("midrst_lsu_ready", bus.lsu_req_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    lsuRespCount = 0; ifuRespCount = 0;
    manResp = 1; manData = 64'h9999999999999999;
    tick(1);
    manResp = 0;
    tick(1);
    checkOutput("late_resp_lsu_pulses", lsuRespCount, 0);
    checkOutput("late_resp_ifu_pulses", ifuRespCount, 0);
    memManual = 0; manReady = 0;
    memData = 64'h5555AAAA5555AAAA;
    tick(1);
    applyStimulus(0, 0, 64'h80004000, 64'h0, 8'hFF);
    waitResp(0, d, lat);
    checkOutput("after_rst_data", d, 64'h5555AAAA5555AAAA);
    checkOutput("after_rst_latency", lat, 2);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
